// File: rtl/signtrunc_if.sv
// Valid/ready bus carrying a wide signed word into the narrowing stage and the
// narrowed word plus its overflow flag out of it.
interface signtrunc_if #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              in_sat;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_data;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, in_sat, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_sat, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/signtrunc.sv
// Pipelined signed narrowing stage: saturates or wraps an N_IN-bit word to N_OUT
// bits, flags overflow, and keeps a saturating count of overflowing words.
module signtrunc #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    signtrunc_if.slave       bus,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Overflow when the top N_IN-N_OUT+1 bits are not all equal.
    function automatic logic f_ovf(input logic [N_IN-1:0] d);
        logic [N_IN-N_OUT:0] top;
        top = d[N_IN-1:N_OUT-1];
        return ~((&top) | ~(|top));
    endfunction

    function automatic logic [N_OUT-1:0] f_narrow(input logic [N_IN-1:0] d,
                                                  input logic sat);
        logic [N_OUT-1:0] res;
        if (sat && f_ovf(d)) begin
            res = d[N_IN-1] ? {1'b1, {(N_OUT-1){1'b0}}} : {1'b0, {(N_OUT-1){1'b1}}};
        end else begin
            res = d[N_IN-1-(N_IN-N_OUT):0];
        end
        return res;
    endfunction

    state_e           state_q, state_d;
    logic [N_OUT-1:0] or_data_q, or_data_d;
    logic             or_ovf_q, or_ovf_d;
    logic [N_OUT-1:0] sk_data_q, sk_data_d;
    logic             sk_ovf_q, sk_ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_s;
    logic             xfer_s;
    logic [N_OUT-1:0] new_data_s;
    logic             new_ovf_s;

    // Next-state, storage and counter update from this cycle's handshakes.
    always_comb begin
        accept_s    = bus.in_valid && in_ready_q;
        xfer_s      = out_valid_q && bus.out_ready;
        new_data_s  = f_narrow(bus.in_data, bus.in_sat);
        new_ovf_s   = f_ovf(bus.in_data);
        state_d     = state_q;
        or_data_d   = or_data_q;
        or_ovf_d    = or_ovf_q;
        sk_data_d   = sk_data_q;
        sk_ovf_d    = sk_ovf_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    or_data_d = new_data_s;
                    or_ovf_d  = new_ovf_s;
                    state_d   = ST_ONE;
                end else begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && xfer_s) begin
                    or_data_d = new_data_s;
                    or_ovf_d  = new_ovf_s;
                    state_d   = ST_ONE;
                end else if (accept_s) begin
                    sk_data_d = new_data_s;
                    sk_ovf_d  = new_ovf_s;
                    state_d   = ST_FULL;
                end else if (xfer_s) begin
                    state_d   = ST_EMPTY;
                end else begin
                    state_d   = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain of OR can happen.
                if (xfer_s) begin
                    or_data_d = sk_data_q;
                    or_ovf_d  = sk_ovf_q;
                    state_d   = ST_ONE;
                end else begin
                    state_d   = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (clr_count) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (accept_s && new_ovf_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            or_data_q   <= {N_OUT{1'b0}};
            or_ovf_q    <= 1'b0;
            sk_data_q   <= {N_OUT{1'b0}};
            sk_ovf_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            or_data_q   <= or_data_d;
            or_ovf_q    <= or_ovf_d;
            sk_data_q   <= sk_data_d;
            sk_ovf_q    <= sk_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = or_data_q;
    assign bus.out_ovf   = or_ovf_q;
    assign ovf_count     = cnt_q;

endmodule

// File: tb/tb_signtrunc.sv
// Directed and random-soak checks of signtrunc with N_IN=16, N_OUT=8, CNT_W=4.
module tb_signtrunc;

    logic       clk;
    logic       rst;
    logic       clr_count;
    logic [3:0] ovf_count;
    int         checks;
    int         errors;
    logic [8:0] exp_q[$];

    signtrunc_if #(.N_IN(16), .N_OUT(8)) bus ();

    signtrunc #(.N_IN(16), .N_OUT(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: range test on the signed value, independent of bit patterns.
    function automatic logic [8:0] model(input logic [15:0] d, input logic sat);
        int v;
        logic ovf;
        logic [7:0] r;
        v   = int'($signed(d));
        ovf = (v > 127) || (v < -128);
        if (ovf && sat) r = (v > 0) ? 8'h7F : 8'h80;
        else            r = d[7:0];
        return {ovf, r};
    endfunction

    task automatic send(input string tag, input logic [15:0] d, input logic sat,
                        input logic [7:0] exp_d, input logic exp_ovf);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sat   = sat;
        check_eq({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        step();
        check_eq({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_dat"}, 32'(bus.out_data), 32'(exp_d));
        check_eq({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
    endtask

    initial begin
        int received;
        int cycles;
        logic [8:0] e;
        logic acc;
        logic xfer;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        clr_count     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0055;
        bus.in_sat    = 1'b1;
        bus.out_ready = 1'b1;

        // Reset with in_valid high
        step();
        step();
        check_eq("rst_rdy", 32'(bus.in_ready), 32'd0);
        check_eq("rst_vld", 32'(bus.out_valid), 32'd0);
        check_eq("rst_cnt", 32'(ovf_count), 32'd0);
        check_eq("rst_dat", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        step();
        check_eq("post_rst_rdy", 32'(bus.in_ready), 32'd1);
        check_eq("post_rst_vld", 32'(bus.out_valid), 32'd0);

        // Saturate mode
        send("s0", 16'h007F, 1'b1, 8'h7F, 1'b0);
        send("s1", 16'hFF80, 1'b1, 8'h80, 1'b0);
        send("s2", 16'h0080, 1'b1, 8'h7F, 1'b1);
        send("s3", 16'hFF7F, 1'b1, 8'h80, 1'b1);
        send("s4", 16'h8000, 1'b1, 8'h80, 1'b1);
        send("s5", 16'h7FFF, 1'b1, 8'h7F, 1'b1);
        bus.in_valid = 1'b0;
        step();
        check_eq("sat_cnt", 32'(ovf_count), 32'd4);
        check_eq("sat_drain", 32'(bus.out_valid), 32'd0);

        // Wrap mode
        send("w0", 16'h0123, 1'b0, 8'h23, 1'b1);
        send("w1", 16'hFFFE, 1'b0, 8'hFE, 1'b0);
        send("w2", 16'hFE00, 1'b0, 8'h00, 1'b1);
        bus.in_valid = 1'b0;
        step();
        check_eq("wrap_cnt", 32'(ovf_count), 32'd6);

        // Backpressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sat    = 1'b1;
        bus.in_data   = 16'h0001;
        step();
        check_eq("bp_rdy1", 32'(bus.in_ready), 32'd1);
        bus.in_data = 16'h0002;
        step();
        check_eq("bp_rdy2", 32'(bus.in_ready), 32'd0);
        bus.in_data = 16'h0003;
        step();
        check_eq("bp_rdy3", 32'(bus.in_ready), 32'd0);
        check_eq("bp_hold_dat", 32'(bus.out_data), 32'h01);
        check_eq("bp_hold_vld", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check_eq("bp_o2", 32'(bus.out_data), 32'h02);
        check_eq("bp_o2_vld", 32'(bus.out_valid), 32'd1);
        check_eq("bp_rdy_up", 32'(bus.in_ready), 32'd1);
        step();
        check_eq("bp_o3", 32'(bus.out_data), 32'h03);
        check_eq("bp_o3_vld", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        step();
        check_eq("bp_empty", 32'(bus.out_valid), 32'd0);

        // Counter saturation and clear priority
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        check_eq("cnt_clr", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 17; i++) begin
            send("cnt_w", 16'h7FFF, 1'b1, 8'h7F, 1'b1);
        end
        bus.in_valid = 1'b0;
        step();
        check_eq("cnt_sat", 32'(ovf_count), 32'd15);
        clr_count = 1'b1;
        send("cnt_clr_acc", 16'h8000, 1'b1, 8'h80, 1'b1);
        clr_count = 1'b0;
        check_eq("cnt_clr_pri", 32'(ovf_count), 32'd0);
        send("cnt_one", 16'h0100, 1'b0, 8'h00, 1'b1);
        bus.in_valid = 1'b0;
        step();
        check_eq("cnt_after", 32'(ovf_count), 32'd1);

        // Reset while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0010;
        step();
        bus.in_data = 16'h0011;
        step();
        check_eq("full_rdy", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        check_eq("frst_vld", 32'(bus.out_valid), 32'd0);
        check_eq("frst_cnt", 32'(ovf_count), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check_eq("frst_rdy", 32'(bus.in_ready), 32'd1);
        step();
        check_eq("frst_stale", 32'(bus.out_valid), 32'd0);
        send("frst_new", 16'h0005, 1'b1, 8'h05, 1'b0);
        bus.in_valid = 1'b0;
        step();

        // Random valid/ready soak against a reference queue
        received = 0;
        cycles   = 0;
        exp_q.delete();
        while (received < 10000 && cycles < 80000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_sat    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) bus.in_data = 16'($urandom_range(0, 400)) - 16'd200;
            else                           bus.in_data = 16'($urandom);
            acc  = bus.in_valid && bus.in_ready;
            xfer = bus.out_valid && bus.out_ready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check_eq("soak_spurious", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("soak_dat", 32'(bus.out_data), 32'(e[7:0]));
                    check_eq("soak_ovf", 32'(bus.out_ovf), 32'(e[8]));
                end
                received++;
            end
            if (acc) exp_q.push_back(model(bus.in_data, bus.in_sat));
            step();
            cycles++;
        end
        check_eq("soak_count", 32'(received), 32'd10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
